// File: rtl/prog_exc_seq.sv
// Program-interrupt sequencer: takes a captured program fault through flush,
// SRR0/SRR1/ESR save and MSR/fetch redirect to the IVPR/IVOR6 vector.
module prog_exc_seq #(
    parameter logic [0:31] MSR_KEEP_MASK = 32'h0002_1200,
    parameter int          ESR_PIL_BIT   = 4,
    parameter int          ESR_PPR_BIT   = 5,
    parameter int          ESR_PTR_BIT   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        progErr,
    input  logic [2:0]  progErrCode,
    input  logic [0:31] excPC,
    input  logic [0:31] MSR,
    input  logic [0:31] IVPR,
    input  logic [0:31] IVOR6,
    input  logic        hold,
    output logic        ack,
    output logic        flush,
    output logic        busy,
    output logic        SRR0_we,
    output logic [0:31] SRR0_wd,
    output logic        SRR1_we,
    output logic [0:31] SRR1_wd,
    output logic        ESR_we,
    output logic [0:31] ESR_wd,
    output logic        MSR_we,
    output logic [0:31] MSR_wd,
    output logic        npc_we,
    output logic [0:31] npc
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        SAVE,
        VECTOR
    } state_t;

    state_t      state;
    logic        pend;
    logic [2:0]  code_q;
    logic [0:31] pc_q;
    logic [0:31] msr_q;

    // One-hot ESR cause, illegal beats privilege beats trap; a zero code reports trap.
    function automatic logic [0:31] esrValue(input logic [2:0] code);
        logic [0:31] v;
        v = '0;
        if (code[2])
            v[ESR_PIL_BIT] = 1'b1;
        else if (code[1])
            v[ESR_PPR_BIT] = 1'b1;
        else
            v[ESR_PTR_BIT] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pend    <= 1'b0;
            code_q  <= 3'b000;
            pc_q    <= '0;
            msr_q   <= '0;
            ack     <= 1'b0;
            flush   <= 1'b0;
            busy    <= 1'b0;
            SRR0_we <= 1'b0;
            SRR0_wd <= '0;
            SRR1_we <= 1'b0;
            SRR1_wd <= '0;
            ESR_we  <= 1'b0;
            ESR_wd  <= '0;
            MSR_we  <= 1'b0;
            MSR_wd  <= '0;
            npc_we  <= 1'b0;
            npc     <= '0;
        end else begin
            // NOTE: outputs are registered against the next state, so every strobe
            // and data bus falls back to zero unless the state being entered drives it.
            ack     <= 1'b0;
            flush   <= 1'b0;
            busy    <= 1'b1;
            SRR0_we <= 1'b0;
            SRR0_wd <= '0;
            SRR1_we <= 1'b0;
            SRR1_wd <= '0;
            ESR_we  <= 1'b0;
            ESR_wd  <= '0;
            MSR_we  <= 1'b0;
            MSR_wd  <= '0;
            npc_we  <= 1'b0;
            npc     <= '0;

            case (state)
                IDLE: begin
                    if (progErr) begin
                        if (!pend) begin
                            code_q <= progErrCode;
                            pc_q   <= excPC;
                            msr_q  <= MSR;
                        end
                        pend  <= 1'b1;
                        state <= FLUSH;
                        flush <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                        if (!pend && progErrCode != 3'b000) begin
                            code_q <= progErrCode;
                            pc_q   <= excPC;
                            msr_q  <= MSR;
                            pend   <= 1'b1;
                        end
                    end
                end

                FLUSH: begin
                    if (hold) begin
                        flush <= 1'b1;
                    end else begin
                        state   <= SAVE;
                        SRR0_we <= 1'b1;
                        SRR0_wd <= pc_q;
                        SRR1_we <= 1'b1;
                        SRR1_wd <= msr_q;
                        ESR_we  <= 1'b1;
                        ESR_wd  <= esrValue(code_q);
                    end
                end

                SAVE: begin
                    state  <= VECTOR;
                    MSR_we <= 1'b1;
                    MSR_wd <= msr_q & MSR_KEEP_MASK;
                    npc_we <= 1'b1;
                    npc    <= {IVPR[0:15], IVOR6[16:27], 4'b0000};
                    ack    <= 1'b1;
                end

                VECTOR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    pend  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/prog_exc_seq.md
Name: prog_exc_seq

Overview:
- Program-interrupt sequencer that sits directly downstream of the program-error detector.
- Consumes the detector's sticky error flag and 3-bit cause code {illegal, privilege, trap}.
- Performs the Book E program interrupt: flush the pipeline, save PC and MSR to SRR0/SRR1, write ESR, update MSR, redirect fetch to IVPR/IVOR6.
- Returns a one-cycle ack that clears the detector's flag.

Parameters:
- MSR_KEEP_MASK, 32'h0002_1200, MSR bits preserved on entry (CE bit14, ME bit19, DE bit22, bit0 = MSB); all other bits cleared.
- ESR_PIL_BIT, 4, ESR bit index (bit0 = MSB) for illegal instruction.
- ESR_PPR_BIT, 5, ESR bit index for privileged instruction.
- ESR_PTR_BIT, 6, ESR bit index for trap.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- progErr  in  1  sticky error request from the detector; rises one cycle after the cause is presented
- progErrCode  in  3  {illegal, privilege, trap}, combinational, valid in the cycle the fault is detected
- excPC  in  [0:31]  address of the instruction currently checked by the detector
- MSR  in  [0:31]  current MSR
- IVPR  in  [0:31]  vector prefix; bits [0:15] used
- IVOR6  in  [0:31]  program vector offset; bits [16:27] used
- hold  in  1  pipeline-drain stall; holds the FSM in FLUSH while high
- ack  out  1  one-cycle pulse; clears the detector's flag
- flush  out  1  kill all younger instructions
- busy  out  1  high in any state other than IDLE
- SRR0_we  out  1  SRR0 write enable
- SRR0_wd  out  [0:31]  SRR0 write data
- SRR1_we  out  1  SRR1 write enable
- SRR1_wd  out  [0:31]  SRR1 write data
- ESR_we  out  1  ESR write enable
- ESR_wd  out  [0:31]  ESR write data
- MSR_we  out  1  MSR write enable
- MSR_wd  out  [0:31]  MSR write data
- npc_we  out  1  next-PC override enable
- npc  out  [0:31]  next-PC value

Behaviour:
- Reset:
  - state=IDLE, pend=0, code_q=0, pc_q=0, msr_q=0.
  - All *_we, ack, flush and busy = 0; all data outputs = 0.
- Capture (IDLE only):
  - If pend=0 and progErrCode!=0, register code_q<=progErrCode, pc_q<=excPC, msr_q<=MSR, and set pend<=1.
  - While pend=1, later non-zero codes are ignored (first fault wins).
- FSM states: IDLE, FLUSH, SAVE, VECTOR.
  - IDLE -> FLUSH when progErr=1 and pend=1.
  - progErr=1 with pend=0 in IDLE is treated as a same-cycle capture: use the current inputs and go to FLUSH.
  - FLUSH: flush=1 every cycle in this state. Go to SAVE on the first cycle hold=0; otherwise stay.
  - SAVE, single cycle:
    - SRR0_we=SRR1_we=ESR_we=1.
    - SRR0_wd=pc_q, SRR1_wd=msr_q.
    - ESR_wd has exactly one bit set, by priority illegal > privilege > trap (code_q[2] -> ESR_PIL_BIT, code_q[1] -> ESR_PPR_BIT, else ESR_PTR_BIT).
    - Next state: VECTOR.
  - VECTOR, single cycle:
    - MSR_we=npc_we=ack=1.
    - MSR_wd = msr_q & MSR_KEEP_MASK.
    - npc = {IVPR[0:15], IVOR6[16:27], 4'b0000}.
    - pend<=0. Next state: IDLE.
- Minimum latency from progErr rise to ack is 3 cycles: IDLE sample, FLUSH, SAVE, then ack in VECTOR.
- Outputs are Moore, decoded from state. Write-data buses are 0 whenever their enable is low.
- During FLUSH/SAVE/VECTOR, progErrCode and progErr are ignored; a fault arriving in those cycles is not captured.
- After ack, the detector's flag is low from the next cycle; IDLE resumes capture in that cycle.
- code_q=0 on entry (defensive case): the trap bit is written.
- rst mid-sequence: return to IDLE next edge, clear pend, and issue no further writes. A partially completed SAVE is not rolled back.

Test Plan:
1. Illegal fault:
   - Stimulus: progErrCode=3'b100 with excPC=32'h0000_1000, MSR=32'h0002_D200; progErr=1 next cycle.
   - Required: flush 1 cycle, SRR0_wd=32'h0000_1000, SRR1_wd=32'h0002_D200, ESR_wd=32'h0800_0000, MSR_wd=32'h0002_1200.
   - With IVPR=32'hFFFF_0000 and IVOR6=32'h0000_0700: npc=32'hFFFF_0700, ack 3 cycles after progErr.
2. Combined code 3'b011 (privilege+trap):
   - Required: ESR_wd=32'h0400_0000 (PPR only); exactly one ack pulse.
3. Pipeline drain:
   - Stimulus: hold=1 for 4 cycles after entering FLUSH.
   - Required: flush high 5 cycles; SRR writes occur in the cycle after hold falls; no ack before that.
4. Back-to-back faults:
   - Stimulus: second code 3'b001 at pc 32'h0000_2000 presented while pend=1 in IDLE.
   - Required: SRR0_wd=32'h0000_1000 (first fault kept). A new fault after ack produces a second full sequence with SRR0_wd=32'h0000_2004 when that pc is presented.
5. Reset mid-sequence:
   - Stimulus: rst asserted in SAVE.
   - Required: next cycle state IDLE, all enables 0, busy=0, no MSR_we/npc_we/ack. A fresh fault afterwards is serviced normally.
6. Vector alignment:
   - Stimulus: IVOR6=32'hFFFF_FFFF, IVPR=32'h1234_FFFF.
   - Required: npc=32'h1234_FFF0.
